// File: rtl/reg_bank_arbiter.sv
// Shared register bank with two req/gnt requesters, round-robin arbitration
// and a synchronous bank-wide clear; one bank access per clock.
module reg_bank_arbiter #(
    parameter int unsigned  NREG = 4,
    parameter int unsigned  W    = 4,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_all,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [W-1:0]  a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [W-1:0]  a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [W-1:0]  b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [W-1:0]  b_rdata,
    output logic          last_gnt
);

    logic [W-1:0] bank [NREG];
    logic         a_elig;
    logic         b_elig;
    logic         win_a;
    logic         win_b;

    // A port in its own gnt cycle is not eligible, so a held req is never served twice.
    always_comb begin
        a_elig = a_req & ~a_gnt;
        b_elig = b_req & ~b_gnt;
        win_a  = a_elig & (~b_elig | last_gnt);
        win_b  = b_elig & (~a_elig | ~last_gnt);
    end

    // Bank storage: reset and clear wipe every entry; otherwise at most one write.
    always_ff @(posedge clk) begin
        if (!reset || clr_all) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                bank[AW'(i)] <= '0;
            end
        end else if (win_a && a_we) begin
            bank[a_addr] <= a_wdata;
        end else if (win_b && b_we) begin
            bank[b_addr] <= b_wdata;
        end
    end

    // Handshake outputs, read data and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            last_gnt <= 1'b1;
        end else if (clr_all) begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_gnt    <= win_a;
            b_gnt    <= win_b;
            a_rvalid <= win_a & ~a_we;
            b_rvalid <= win_b & ~b_we;
            if (win_a) begin
                last_gnt <= 1'b0;
                if (!a_we) begin
                    a_rdata <= bank[a_addr];
                end
            end else if (win_b) begin
                last_gnt <= 1'b1;
                if (!b_we) begin
                    b_rdata <= bank[b_addr];
                end
            end
        end
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Two-port arbiter and controller for a shared bank of NREG clocked registers, each W bits wide. Two independent requesters (A and B) issue read or write transactions through a req/gnt handshake. A round-robin scheduler serialises them onto the single bank write/read path, one transaction per clock. A synchronous bank-clear command sits above both requesters. The block sits between bus-side masters and the register storage they share.

## Interface
Parameters:
- NREG, 4, number of registers in the bank; must be a power of two, minimum 2
- W, 4, register and data width in bits
- AW, log2(NREG) (2 at default), address width; derived, not overridden

Ports:
- clk  in  1  rising-edge clock, sole clock of the block
- reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clk
- clr_all  in  1  synchronous clear of every bank entry
- a_req  in  1  requester A transaction request
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  AW  A register index
- a_wdata  in  W  A write data
- a_gnt  out  1  A transaction accepted; one-cycle pulse
- a_rvalid  out  1  A read data valid; one-cycle pulse
- a_rdata  out  W  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B
- last_gnt  out  1  round-robin pointer: 0 = A was served last, 1 = B was served last

## Operation
- Reset (reset=0 at an edge): all bank entries <= 0; a_gnt, b_gnt, a_rvalid, b_rvalid <= 0; a_rdata, b_rdata <= 0; last_gnt <= 1, so A wins the first tie. Reset overrides clr_all and all requests.
- Eligibility: port X is eligible at an edge when x_req=1 and x_gnt=0 in that cycle. A request held high during its own gnt cycle is ignored, which prevents double service. A given port can be served at most every other cycle.
- Priority at each edge, highest first: reset, clr_all, arbitration.
- clr_all=1 (with reset=1): all entries <= 0. No grant is issued that cycle. All gnt and rvalid outputs <= 0. last_gnt and rdata hold. Pending requests stay pending.
- Arbitration: if only one port is eligible, that port wins. If both are eligible, the port not equal to last_gnt wins. If neither is eligible, there is no grant and last_gnt holds.
- Winner X at an edge:
  - x_gnt <= 1 for exactly the next cycle.
  - last_gnt <= X.
  - If x_we=1: bank[x_addr] <= x_wdata.
  - If x_we=0: x_rdata <= bank[x_addr], using the value before any update at this edge, and x_rvalid <= 1 alongside x_gnt.
- Loser: no gnt, no side effect. It stays eligible and must hold req, we, addr and wdata stable until it sees gnt.
- x_rdata holds its value until the next granted read on that port. Writes and clr_all do not alter x_rdata.
- Only one bank access per cycle, so read/write collisions are impossible.

## Timing
- Uncontended latency: req sampled at edge N produces gnt (and rvalid/rdata for a read) high during cycle N to N+1. A write is visible in the bank after edge N.
- Contended: the loser is granted at the next edge, one cycle later, because the winner is ineligible during its gnt cycle.
- Sustained both-port load: grants alternate A, B, A, B. Each port gets 50% of cycles, with zero idle cycles.
- Each requester may deassert req, or present a new transaction, in the cycle its gnt is high. A new transaction presented then is sampled at the following edge.
- Mid-transaction reset or clr_all: the request is not acknowledged. The requester keeps req asserted and is granted after release.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- Reset: drive reset=0 for 2 cycles with a_req=b_req=1. Required: no gnt during reset; last_gnt=1, all rdata=0, reading any address after release returns 0.
- Uncontended write then read: A writes addr 2 = 4'hA at edge N, so a_gnt=1 in cycle N+1. A then reads addr 2, giving a_rvalid=1 and a_rdata=4'hA one cycle after the read is sampled. b_gnt stays 0 throughout.
- Tie-break and round-robin: after reset, A and B both request continuously. Required grant order: A, B, A, B, with last_gnt toggling 0, 1, 0, 1 and no idle cycles.
- Held request: A holds a_req=1 with B idle. Required: a_gnt pattern 1, 0, 1, 0, so the same transaction is never double-served in the gnt cycle.
- clr_all collision: bank holds 4'h5 at every address. Assert clr_all in the same cycle as a write request from A (addr 1, 4'hF). Required: no gnt that cycle and all entries 0. A is granted the next cycle, after which addr 1 = 4'hF and all other addresses stay 0.
- Reset mid-contention: both requesters pending, last_gnt=0, then a reset pulse. Required: gnts cleared and last_gnt=1, so A is granted first after release.
